sign_extend: RTL and testbench
==============================

# sign_extend

Immediate-extension unit for the CPU decode stage. It widens the 9-bit instruction immediate to the 16-bit datapath width. A purely combinational sign-extended output feeds the ALU operand mux directly. A registered, mode-selectable copy with a valid flag feeds the pipelined execute stage.

## Interface
- `IN_W`, default 9: immediate width; must be at least 2 and less than `OUT_W`.
- `OUT_W`, default 16: datapath width.
- `clk`  in  1  rising-edge clock; drives the registered path only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `immed`  in  IN_W  raw immediate field.
- `ext_immed`  out  OUT_W  combinational sign extension of `immed`.
- `mode`  in  2  extension mode for the registered path.
- `in_valid`  in  1  qualifies `immed`/`mode` for capture.
- `ext_immed_q`  out  OUT_W  registered extension result.
- `out_valid`  out  1  `ext_immed_q` holds a valid result.

## Operation
- `ext_immed` = {(OUT_W-IN_W) copies of `immed[IN_W-1]`, `immed`}, always.
  - Independent of `clk`, `rst_n`, `mode` and `in_valid`.
  - Bit pattern is preserved; the MSB is replicated.
- Registered path computes `r` from `immed` and `mode`:
  - 00 SEXT: same value as `ext_immed`.
  - 01 ZEXT: {zeros, `immed`}.
  - 10 SEXT_SHL1: sign-extended value shifted left 1, LSB 0. Used for branch offsets; the top extended bit is dropped.
  - 11 UPPER: `immed` placed in bits [OUT_W-1 : OUT_W-IN_W]; lower bits 0.
- Capture rule on each rising `clk` while `rst_n`=1:
  - If `in_valid`=1: `ext_immed_q` <= `r` and `out_valid` <= 1.
  - Else: `ext_immed_q` holds its value and `out_valid` <= 0.
- Unconnected or X `mode`/`in_valid` must not affect `ext_immed`.
- No overflow is possible; all widths are exact.

## Timing
- `ext_immed`: zero-cycle, combinational; valid within the same delta as an `immed` change.
- Registered path: 1-cycle latency from a sampled `in_valid` to `out_valid`/`ext_immed_q`.
- Back-to-back `in_valid` cycles give back-to-back results. There is no backpressure and no stall input.
- Reset values: `ext_immed_q` = 0 and `out_valid` = 0, forced asynchronously on the falling edge of `rst_n`.
- Reset mid-stream: any in-flight result is discarded. The first capture happens on the first rising edge after `rst_n` returns high.
- `in_valid` and a reset release on the same edge: reset dominates for that edge.

## Configuration
- `SIGN_EXTEND_SHIFT_EN` defined: modes 10 and 11 behave as specified above.
- `SIGN_EXTEND_SHIFT_EN` undefined: the shift/upper logic is not built. Modes 10 and 11 decode as SEXT (00), and `mode[1]` is ignored.
- `ext_immed` is unaffected in either case.

## Structure
- Shared package `sign_extend_pkg`:
  - enum `ext_mode_t` (SEXT, ZEXT, SEXT_SHL1, UPPER).
  - Constants `IMM_W`=9 and `DATA_W`=16.
- One sub-module, `sign_extend_core`:
  - Combinational; inputs `immed` and `mode`, output `r`.
  - Instantiated twice: once with `mode` tied to SEXT to drive `ext_immed`, and once for the registered path.
- Top level holds only the output register and the valid flop.

## Test plan
- Combinational sweep, no clock: `immed` 0x000 -> `ext_immed` 0x0000; 0x001 -> 0x0001; 0x100 -> 0xFF00; 0x1FF -> 0xFFFF; 0x0FF -> 0x00FF. Each is checked 10 time units after the change.
- Registered SEXT/ZEXT: `in_valid`=1 with `immed`=0x1FF.
  - `mode`=00: next edge gives `ext_immed_q`=0xFFFF, `out_valid`=1.
  - `mode`=01: following edge gives 0x01FF.
- Shift modes (macro defined): `immed`=0x1FF.
  - `mode`=10 -> 0xFFFE.
  - `mode`=11 -> 0xFF80.
  - `immed`=0x080 with `mode`=10 -> 0x0100.
- Macro undefined: `immed`=0x100 with `mode`=11 -> 0xFF00.
- Reset: assert `rst_n`=0 between edges while `out_valid`=1. Outputs clear immediately to 0, with no clock edge needed. `ext_immed` keeps tracking `immed` throughout reset.
- Valid gating: `in_valid` pattern 1,0,1 -> `out_valid` pattern 1,0,1 one cycle later. `ext_immed_q` holds its value during the 0 cycle.

Source files
------------

// File: rtl/sign_extend_pkg.sv
// sign_extend_pkg: shared extension modes and default widths for the immediate-extension unit
package sign_extend_pkg;
    localparam int IMM_W  = 9;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        SEXT      = 2'b00,
        ZEXT      = 2'b01,
        SEXT_SHL1 = 2'b10,
        UPPER     = 2'b11
    } ext_mode_t;
endpackage

// File: rtl/sign_extend_if.sv
// sign_extend_if: decode-stage immediate bus
//   immed, mode, in_valid           : driven by the decoder (master)
//   ext_immed, ext_immed_q, out_valid : driven by the extension unit (slave)
interface sign_extend_if
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
);
    logic [IN_W-1:0]  immed;
    ext_mode_t        mode;
    logic             in_valid;
    logic [OUT_W-1:0] ext_immed;
    logic [OUT_W-1:0] ext_immed_q;
    logic             out_valid;

    modport master (
        output immed, mode, in_valid,
        input  ext_immed, ext_immed_q, out_valid
    );

    modport slave (
        input  immed, mode, in_valid,
        output ext_immed, ext_immed_q, out_valid
    );
endinterface

// File: rtl/sign_extend_core.sv
// sign_extend_core: combinational immediate widening selected by mode
//   immed : raw immediate, mode : extension mode, r : widened result
//   SIGN_EXTEND_SHIFT_EN enables the SEXT_SHL1 and UPPER modes
module sign_extend_core
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  immed,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] r
);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    assign sext = {{(OUT_W-IN_W){immed[IN_W-1]}}, immed};
    assign zext = {{(OUT_W-IN_W){1'b0}}, immed};

`ifdef SIGN_EXTEND_SHIFT_EN
    always_comb begin
        r = mode == SEXT_SHL1 ? {sext[OUT_W-2:0], 1'b0} :
            mode == UPPER     ? {immed, {(OUT_W-IN_W){1'b0}}} :
            mode == ZEXT      ? zext : sext;
    end
`else
    // Without the shift logic, the two upper modes fall back to plain SEXT.
    always_comb begin
        r = mode == ZEXT ? zext : sext;
    end
`endif
endmodule

// File: rtl/sign_extend.sv
// sign_extend: 9->16 bit immediate extension with combinational and registered outputs
//   clk, rst_n : clock (registered path only) and async active-low reset
//   bus        : sign_extend_if slave (immed/mode/in_valid in, ext_immed/ext_immed_q/out_valid out)
//   SIGN_EXTEND_SHIFT_EN enables the SEXT_SHL1 and UPPER modes on the registered path
module sign_extend
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    sign_extend_if.slave bus
);
    logic [OUT_W-1:0] r;

    // Mode is tied off so the ALU operand path never sees mode or in_valid.
    sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_comb (
        .immed (bus.immed),
        .mode  (SEXT),
        .r     (bus.ext_immed)
    );

    sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_reg (
        .immed (bus.immed),
        .mode  (bus.mode),
        .r     (r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ext_immed_q <= '0;
            bus.out_valid   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.ext_immed_q <= r;
        end
    end
endmodule

// File: tb/tb_sign_extend.sv
// tb_sign_extend: directed self-checking bench for sign_extend
module tb_sign_extend;
    import sign_extend_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    sign_extend_if bus ();

    sign_extend dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.immed    = 9'h000;
        bus.mode     = SEXT;
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_q", bus.ext_immed_q, 16'h0000);
        check("reset_v", {15'd0, bus.out_valid}, 16'h0000);

        bus.immed = 9'h000; #10; check("comb_000", bus.ext_immed, 16'h0000);
        bus.immed = 9'h001; #10; check("comb_001", bus.ext_immed, 16'h0001);
        bus.immed = 9'h100; #10; check("comb_100", bus.ext_immed, 16'hFF00);
        bus.immed = 9'h1FF; #10; check("comb_1ff", bus.ext_immed, 16'hFFFF);
        bus.immed = 9'h0FF; #10; check("comb_0ff", bus.ext_immed, 16'h00FF);

        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.immed    = 9'h1FF;
        bus.mode     = SEXT;
        tick();
        check("sext_q", bus.ext_immed_q, 16'hFFFF);
        check("sext_v", {15'd0, bus.out_valid}, 16'h0001);
        bus.mode = ZEXT;
        tick();
        check("zext_q", bus.ext_immed_q, 16'h01FF);
        check("zext_comb", bus.ext_immed, 16'hFFFF);

        bus.mode = SEXT_SHL1;
        tick();
`ifdef SIGN_EXTEND_SHIFT_EN
        check("shl1_1ff", bus.ext_immed_q, 16'hFFFE);
`else
        check("shl1_1ff", bus.ext_immed_q, 16'hFFFF);
`endif
        bus.mode = UPPER;
        tick();
`ifdef SIGN_EXTEND_SHIFT_EN
        check("upper_1ff", bus.ext_immed_q, 16'hFF80);
`else
        check("upper_1ff", bus.ext_immed_q, 16'hFFFF);
`endif
        bus.immed = 9'h080;
        bus.mode  = SEXT_SHL1;
        tick();
`ifdef SIGN_EXTEND_SHIFT_EN
        check("shl1_080", bus.ext_immed_q, 16'h0100);
`else
        check("shl1_080", bus.ext_immed_q, 16'h0080);
`endif
        bus.immed = 9'h100;
        bus.mode  = UPPER;
        tick();
`ifdef SIGN_EXTEND_SHIFT_EN
        check("upper_100", bus.ext_immed_q, 16'h8000);
`else
        check("upper_100", bus.ext_immed_q, 16'hFF00);
`endif
        check("pre_rst_v", {15'd0, bus.out_valid}, 16'h0001);

        #3 rst_n = 1'b0;
        #1;
        check("async_rst_q", bus.ext_immed_q, 16'h0000);
        check("async_rst_v", {15'd0, bus.out_valid}, 16'h0000);
        bus.immed = 9'h0FF;
        #1;
        check("rst_comb", bus.ext_immed, 16'h00FF);
        tick();
        check("rst_hold_v", {15'd0, bus.out_valid}, 16'h0000);

        bus.immed = 9'h001;
        bus.mode  = SEXT;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_q", bus.ext_immed_q, 16'h0001);
        check("post_rst_v", {15'd0, bus.out_valid}, 16'h0001);

        bus.immed = 9'h100;
        bus.mode  = ZEXT;
        tick();
        check("gate1_q", bus.ext_immed_q, 16'h0100);
        check("gate1_v", {15'd0, bus.out_valid}, 16'h0001);
        bus.in_valid = 1'b0;
        bus.immed    = 9'h0AA;
        tick();
        check("gate0_q", bus.ext_immed_q, 16'h0100);
        check("gate0_v", {15'd0, bus.out_valid}, 16'h0000);
        bus.in_valid = 1'b1;
        bus.immed    = 9'h155;
        bus.mode     = SEXT;
        tick();
        check("gate2_q", bus.ext_immed_q, 16'hFF55);
        check("gate2_v", {15'd0, bus.out_valid}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
